hello_scroll_ctrl: RTL and testbench
====================================

HELLO_SCROLL_CTRL -- requirements
Module: hello_scroll_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per scroll step (minimum 2).
REQ-002 SHALL have port CLOCK_50  input  1  system clock; all state is updated on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port RUN  input  1  1 = auto-scroll on each tick; 0 = paused.
REQ-005 SHALL have port DIR  input  1  0 = scroll left (pointer +1); 1 = scroll right (pointer -1).
REQ-006 SHALL have port STEP  input  1  single-step request; already synchronous to CLOCK_50.
REQ-007 SHALL have ports HEX3, HEX2, HEX1, HEX0  output  8 each  active-low segments {dp,g..a}; HEX3 is the leftmost digit.
REQ-008 SHALL have port PTR  output  3  current message pointer.

Function
REQ-009 SHALL hold a fixed 8-entry message of 3-bit codes: pos0..7 = 000 H, 001 E, 010 L, 011 L, 100 O, 101, 101, 101 (101 = blank).
REQ-010 SHALL encode codes to segment patterns as: 000->89, 001->86, 010->C7, 011->C7, 100->C0, 101/110/111->FF (hex).
REQ-011 SHALL display a 4-position window: HEX3 = msg[PTR], HEX2 = msg[PTR+1], HEX1 = msg[PTR+2], HEX0 = msg[PTR+3], with all indices mod 8.
REQ-012 SHALL run a free-running divider counter 0..TICK_DIV-1, asserting an internal tick for one cycle when count = TICK_DIV-1, then wrapping to 0.
REQ-013 SHALL run the divider regardless of RUN.
REQ-014 SHALL, when RUN=1 and tick is asserted, change PTR by +1 (DIR=0) or -1 (DIR=1) mod 8 on that edge.
REQ-015 SHALL wrap PTR 7->0 on +1 and 0->7 on -1.
REQ-016 SHALL detect STEP rising edges with a registered previous-value flop; a rising edge is STEP=1 with previous STEP=0.
REQ-017 SHALL, when RUN=0, advance PTR by one in the DIR direction on a STEP rising edge.
REQ-018 SHALL ignore STEP while RUN=1.
REQ-019 SHALL advance PTR by exactly one when a tick and a STEP edge coincide with RUN=0 (in this case the tick is ignored).
REQ-020 SHALL sample DIR on the same edge that advances PTR.
REQ-021 SHALL register HEX3..HEX0: they reflect a PTR update one clock after PTR changes.
REQ-022 SHALL update PTR combinationally-free: PTR is the register output itself.

Reset
REQ-023 SHALL, while RESET=1, immediately force: divider=0, PTR=0, STEP history=0, HEX3=89, HEX2=86, HEX1=C7, HEX0=C7.
REQ-024 SHALL abandon any pending tick or step when RESET is asserted mid-count; the first tick after release occurs TICK_DIV cycles after release.

Configuration
REQ-025 SHALL support macro SCROLL_BLINK_EN.
REQ-026 SHALL, with SCROLL_BLINK_EN defined and RUN=0, toggle a blink flag on every tick, driving all HEX outputs to FF while the flag is set.
REQ-027 SHALL, with SCROLL_BLINK_EN defined, clear the blink flag on reset and whenever RUN=1.
REQ-028 SHALL, without SCROLL_BLINK_EN, hold the paused display static with no blink logic present.

Verification (TICK_DIV=4)
REQ-029 SHALL verify reset: assert RESET mid-count -> HEX3..0 = 89,86,C7,C7 and PTR=0 immediately.
REQ-030 SHALL verify left scroll: RUN=1, DIR=0, 8 ticks -> PTR steps 1..7,0; at PTR=3, HEX3..0 = C7,C0,FF,FF; at PTR=6, HEX3..0 = FF,FF,89,86.
REQ-031 SHALL verify right scroll wrap: RUN=1, DIR=1 from PTR=0 -> first tick gives PTR=7 and HEX3..0 = FF,89,86,C7.
REQ-032 SHALL verify single step: RUN=0, hold STEP=1 for 10 cycles -> PTR advances exactly once; STEP pulses while RUN=1 -> no extra advance.
REQ-033 SHALL verify collision: RUN=0 with a STEP edge on the tick cycle -> PTR changes by exactly 1.
REQ-034 SHALL verify blink (SCROLL_BLINK_EN defined): RUN=0 -> HEX alternates FF and pattern every 4 cycles; setting RUN=1 restores the pattern on the next edge.

Source files
------------

// File: rtl/hello_scroll_ctrl.sv
// Scrolling "HELLO" banner across four active-low 7-segment digits, with auto-scroll and single-step.
// Optional macro SCROLL_BLINK_EN: blinks the paused display on every divider tick.
module hello_scroll_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       RUN,
  input  logic       DIR,
  input  logic       STEP,
  output logic [7:0] HEX3,
  output logic [7:0] HEX2,
  output logic [7:0] HEX1,
  output logic [7:0] HEX0,
  output logic [2:0] PTR
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ptr_q, ptr_d;
  logic          step_prev_q, step_prev_d;
  logic [7:0]    hex3_q, hex3_d;
  logic [7:0]    hex2_q, hex2_d;
  logic [7:0]    hex1_q, hex1_d;
  logic [7:0]    hex0_q, hex0_d;
  logic          tick_s;
  logic          step_edge_s;
  logic          advance_s;
  logic          blank_s;
`ifdef SCROLL_BLINK_EN
  logic          blink_q, blink_d;
`endif

  function automatic logic [2:0] msg_code(input logic [2:0] pos);
    logic [2:0] code;
    case (pos)
      3'd0:    code = 3'b000;
      3'd1:    code = 3'b001;
      3'd2:    code = 3'b010;
      3'd3:    code = 3'b011;
      3'd4:    code = 3'b100;
      default: code = 3'b101;
    endcase
    return code;
  endfunction

  function automatic logic [7:0] seg_of(input logic [2:0] code);
    logic [7:0] seg;
    case (code)
      3'b000:  seg = 8'h89;
      3'b001:  seg = 8'h86;
      3'b010:  seg = 8'hC7;
      3'b011:  seg = 8'hC7;
      3'b100:  seg = 8'hC0;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Divider, step-edge detect, pointer advance and window decode.
  always_comb begin
    tick_s      = (cnt_q == CNT_MAX);
    cnt_d       = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
    step_prev_d = STEP;
    step_edge_s = STEP & ~step_prev_q;
    // While paused a coincident tick is ignored, so a step moves exactly one place.
    advance_s   = RUN ? tick_s : step_edge_s;
    if (advance_s) begin
      ptr_d = DIR ? (ptr_q - 3'd1) : (ptr_q + 3'd1);
    end else begin
      ptr_d = ptr_q;
    end
`ifdef SCROLL_BLINK_EN
    if (RUN) begin
      blink_d = 1'b0;
    end else if (tick_s) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
    blank_s = blink_d;
`else
    blank_s = 1'b0;
`endif
    if (blank_s) begin
      hex3_d = 8'hFF;
      hex2_d = 8'hFF;
      hex1_d = 8'hFF;
      hex0_d = 8'hFF;
    end else begin
      hex3_d = seg_of(msg_code(ptr_q));
      hex2_d = seg_of(msg_code(ptr_q + 3'd1));
      hex1_d = seg_of(msg_code(ptr_q + 3'd2));
      hex0_d = seg_of(msg_code(ptr_q + 3'd3));
    end
  end

  // State and display registers; reset shows the window at pointer 0.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt_q       <= {CW{1'b0}};
      ptr_q       <= 3'd0;
      step_prev_q <= 1'b0;
      hex3_q      <= 8'h89;
      hex2_q      <= 8'h86;
      hex1_q      <= 8'hC7;
      hex0_q      <= 8'hC7;
`ifdef SCROLL_BLINK_EN
      blink_q     <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      step_prev_q <= step_prev_d;
      hex3_q      <= hex3_d;
      hex2_q      <= hex2_d;
      hex1_q      <= hex1_d;
      hex0_q      <= hex0_d;
`ifdef SCROLL_BLINK_EN
      blink_q     <= blink_d;
`endif
    end
  end

  assign HEX3 = hex3_q;
  assign HEX2 = hex2_q;
  assign HEX1 = hex1_q;
  assign HEX0 = hex0_q;
  assign PTR  = ptr_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Directed bench for hello_scroll_ctrl at TICK_DIV=4 with a scoreboard queue of expected PTR/HEX values.
module tb_hello_scroll_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       RUN;
  logic       DIR;
  logic       STEP;
  logic [7:0] HEX3, HEX2, HEX1, HEX0;
  logic [2:0] PTR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [2:0]  ptr;
    logic [31:0] hex;
  } exp_t;

  exp_t sb_q[$];

  hello_scroll_ctrl #(.TICK_DIV(4)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .RUN(RUN),
    .DIR(DIR),
    .STEP(STEP),
    .HEX3(HEX3),
    .HEX2(HEX2),
    .HEX1(HEX1),
    .HEX0(HEX0),
    .PTR(PTR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] seg_ref(input logic [2:0] pos);
    logic [7:0] s;
    case (pos)
      3'd0:    s = 8'h89;
      3'd1:    s = 8'h86;
      3'd2:    s = 8'hC7;
      3'd3:    s = 8'hC7;
      3'd4:    s = 8'hC0;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Expected {HEX3,HEX2,HEX1,HEX0} for a window starting at message position p.
  function automatic logic [31:0] win(input logic [2:0] p);
    logic [31:0] r;
    logic [2:0]  idx;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 3'(i);
      r = {r[23:0], seg_ref(idx)};
    end
    return r;
  endfunction

  function automatic logic [31:0] blink_exp(input logic [2:0] p);
`ifdef SCROLL_BLINK_EN
    return 32'hFFFF_FFFF;
`else
    return win(p);
`endif
  endfunction

  task automatic push(input string tag, input logic [2:0] p, input logic [31:0] h);
    exp_t e;
    e.tag = tag;
    e.ptr = p;
    e.hex = h;
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end else begin
      e = sb_q.pop_front();
      checks++;
      assert (PTR === e.ptr) else begin
        errors++;
        $error("FAIL %s ptr observed=%0h expected=%0h", e.tag, PTR, e.ptr);
      end
      checks++;
      assert ({HEX3, HEX2, HEX1, HEX0} === e.hex) else begin
        errors++;
        $error("FAIL %s hex observed=%08h expected=%08h", e.tag, {HEX3, HEX2, HEX1, HEX0}, e.hex);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    RUN   = 1'b0;
    DIR   = 1'b0;
    STEP  = 1'b0;

    // Asynchronous reset takes effect without a clock edge.
    #1 RESET = 1'b1;
    push("rst_hold", 3'd0, 32'h8986_C7C7);
    #1 check_pop();

    @(negedge CLOCK_50);
    RESET = 1'b0;
    RUN   = 1'b1;
    push("pre_rst", 3'd1, win(3'd1));
    wait_cyc(5);
    check_pop();

    // Reset mid-count with the pointer away from zero.
    #2 RESET = 1'b1;
    push("rst_mid", 3'd0, 32'h8986_C7C7);
    #1 check_pop();
    @(negedge CLOCK_50);
    RESET = 1'b0;

    // First tick must come a full TICK_DIV cycles after release.
    push("pre_tick", 3'd0, win(3'd0));
    wait_cyc(3);
    check_pop();

    for (int k = 1; k <= 8; k++) begin
      push("scroll_tick", 3'(k), win(3'(k - 1)));
      wait_cyc((k == 1) ? 1 : 3);
      check_pop();
      push("scroll_hex", 3'(k), win(3'(k)));
      wait_cyc(1);
      check_pop();
    end

    DIR = 1'b1;
    push("right_tick", 3'd7, win(3'd0));
    wait_cyc(3);
    check_pop();
    push("right_hex", 3'd7, 32'hFF89_86C7);
    wait_cyc(1);
    check_pop();

    // Held STEP while paused advances once; ticks are ignored.
    RUN  = 1'b0;
    STEP = 1'b1;
    push("step_hold", 3'd6, win(3'd6));
    wait_cyc(10);
    check_pop();

    STEP = 1'b0;
    RUN  = 1'b1;
    push("run_tick", 3'd5, win(3'd6));
    wait_cyc(1);
    check_pop();
    STEP = 1'b1;
    wait_cyc(1);
    STEP = 1'b0;
    wait_cyc(1);
    STEP = 1'b1;
    push("run_step_ignored", 3'd5, win(3'd5));
    wait_cyc(1);
    check_pop();

    // STEP edge lands on the tick edge while paused.
    STEP = 1'b0;
    RUN  = 1'b0;
    wait_cyc(4);
    STEP = 1'b1;
    push("collide", 3'd4, win(3'd5));
    wait_cyc(1);
    check_pop();
    STEP = 1'b0;
    push("collide_hex", 3'd4, win(3'd4));
    wait_cyc(1);
    check_pop();

    // Paused display: blinks when the option is built in, static otherwise.
    push("blink_on", 3'd4, blink_exp(3'd4));
    wait_cyc(3);
    check_pop();
    push("blink_off", 3'd4, win(3'd4));
    wait_cyc(4);
    check_pop();
    push("blink_on2", 3'd4, blink_exp(3'd4));
    wait_cyc(4);
    check_pop();
    RUN = 1'b1;
    push("blink_clear", 3'd4, win(3'd4));
    wait_cyc(1);
    check_pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
